// File: rtl/ce_pkg.sv
// ce_pkg: shared constants and types for the channel-estimation re-modulation path.
//   CE_WCOEFF       default width of the signed reference-symbol coefficients
//   CE_SCALE_SHIFT  right shift that removes the Q16 scaling of |C| = 65536
//   CE_ERR_LEN      source_error bit: packet length mismatch
//   CE_ERR_ORPHAN   source_error bit: orphan beats were dropped before this packet
//   CE_WFFT         width of the fftpts length field
//   ce_state_e      framing FSM states
//   ce_side_t       per-beat framing side-band carried down the pipeline
package ce_pkg;

  localparam int unsigned CE_WCOEFF      = 18;
  localparam int unsigned CE_SCALE_SHIFT = 16;
  localparam int unsigned CE_ERR_LEN     = 0;
  localparam int unsigned CE_ERR_ORPHAN  = 1;
  localparam int unsigned CE_WFFT        = 12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ce_state_e;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [1:0]         err;
    logic [CE_WFFT-1:0] fftpts;
  } ce_side_t;

endpackage

// File: rtl/ce_round_sat.sv
// ce_round_sat: round-half-up, arithmetic right shift by Shift, saturate to WOut bits.
// Purely combinational.
//   din   signed WIn-bit input
//   dout  signed WOut-bit result, clamped to [-2^(WOut-1), 2^(WOut-1)-1]
module ce_round_sat #(
  parameter int unsigned WIn   = 35,
  parameter int unsigned WOut  = 16,
  parameter int unsigned Shift = 16
) (
  input  logic signed [WIn-1:0]  din,
  output logic signed [WOut-1:0] dout
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int unsigned WExt = WIn + 1;

  logic signed [WExt-1:0] ext;
  logic signed [WExt-1:0] half;
  logic signed [WExt-1:0] sum;
  logic signed [WExt-1:0] shifted;
  logic        [WExt-WOut:0] top;

  assign ext     = WExt'(din);
  assign half    = {{(WExt - Shift){1'b0}}, 1'b1, {(Shift - 1){1'b0}}};
  assign sum     = ext + half;
  assign shifted = sum >>> Shift;
  // Result fits in WOut bits only if every bit from the WOut sign position upward agrees.
  assign top     = shifted[WExt-1:WOut-1];

  always_comb begin
    dout = shifted[WOut-1:0];
    if (!(&top) && (|top)) begin
      dout = shifted[WExt-1] ? {1'b1, {(WOut - 1){1'b0}}} : {1'b0, {(WOut - 1){1'b1}}};
    end
  end

endmodule

// File: rtl/ce_rs_remod.sv
// ce_rs_remod: re-modulates a channel-estimate stream, Y[k] = H[k] * C[k] / 65536.
// Four-stage pipeline (register H/C, products, sum/difference, round+saturate), one
// complex beat per clock, packet framed with sop/eop and gated by a single pipe enable.
// Optional build macro CE_REMOD_CONJ_EN: multiply by conj(C) instead of C.
// Ports:
//   clk, rst_n_sync                 clock, synchronous active-low reset
//   sink_valid/ready/sop/eop        input handshake and framing
//   sink_real/imag                  H (signed wDataIn)
//   coef_real/imag                  C (signed wCoeff), valid with the sink beat
//   fftpts_in                       expected packet length, taken on the sop beat
//   source_valid/ready/sop/eop      output handshake and framing
//   source_error                    [0] length error, [1] orphans dropped before packet
//   source_real/imag                Y (signed wDataOut)
//   fftpts_out                      length latched when the sop beat reaches the output
module ce_rs_remod
  import ce_pkg::*;
#(
  parameter int unsigned wDataIn  = 16,
  parameter int unsigned wCoeff   = CE_WCOEFF,
  parameter int unsigned wDataOut = 16
) (
  input  logic                       clk,
  input  logic                       rst_n_sync,
  input  logic                       sink_valid,
  output logic                       sink_ready,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic signed [wDataIn-1:0]  sink_real,
  input  logic signed [wDataIn-1:0]  sink_imag,
  input  logic signed [wCoeff-1:0]   coef_real,
  input  logic signed [wCoeff-1:0]   coef_imag,
  input  logic        [11:0]         fftpts_in,
  output logic                       source_valid,
  input  logic                       source_ready,
  output logic                       source_sop,
  output logic                       source_eop,
  output logic        [1:0]          source_error,
  output logic signed [wDataOut-1:0] source_real,
  output logic signed [wDataOut-1:0] source_imag,
  output logic        [11:0]         fftpts_out
);

  localparam int unsigned WProd = wDataIn + wCoeff;
  localparam int unsigned WSum  = WProd + 1;

  logic pipe_en;
  logic accept;

  assign pipe_en    = !source_valid || source_ready;
  assign sink_ready = pipe_en;
  assign accept     = sink_valid && pipe_en;

  // ---------------------------------------------------------------------------------------
  // Framing FSM: decides per accepted beat whether it is forwarded and with which flags.
  // ---------------------------------------------------------------------------------------
  ce_state_e            state_q, state_d;
  logic [CE_WFFT-1:0]   cnt_q, cnt_d, cnt_new;
  logic [CE_WFFT-1:0]   len_q, len_d, len_new;
  logic                 orphan_q, orphan_d;
  logic                 len_hit;
  logic                 fwd;
  ce_side_t             side_in;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    orphan_d = orphan_q;
    cnt_new  = cnt_q + 12'd1;
    len_new  = len_q;
    len_hit  = 1'b0;
    fwd      = 1'b0;
    side_in  = '0;
    if (accept) begin
      if (sink_sop) begin
        cnt_new = 12'd1;
        len_new = fftpts_in;
      end
      if (sink_sop || state_q == RUN) begin
        fwd            = 1'b1;
        len_hit        = (cnt_new == len_new);
        side_in.sop    = sink_sop;
        // Reaching the expected length closes the packet even without eop.
        side_in.eop    = sink_eop || len_hit;
        // Restart inside a packet, early eop, or missing eop are all length errors.
        side_in.err[CE_ERR_LEN]    = (sink_sop && state_q == RUN) || (sink_eop != len_hit);
        side_in.err[CE_ERR_ORPHAN] = sink_sop && orphan_q;
        side_in.fftpts = len_new;
        cnt_d          = cnt_new;
        len_d          = len_new;
        state_d        = side_in.eop ? IDLE : RUN;
        if (sink_sop) begin
          orphan_d = 1'b0;
        end
      end else begin
        orphan_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      orphan_q <= orphan_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Datapath pipeline
  // ---------------------------------------------------------------------------------------
  logic                      v1_q, v2_q, v3_q;
  ce_side_t                  side1_q, side2_q, side3_q;
  logic signed [wDataIn-1:0] hr1_q, hi1_q;
  logic signed [wCoeff-1:0]  cr1_q, ci1_q;
  logic signed [WProd-1:0]   p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [WSum-1:0]    re3_q, im3_q;

  logic signed [WProd-1:0]   hr_x, hi_x, cr_x, ci_x;
  logic signed [WSum-1:0]    rr_x, ii_x, ri_x, ir_x;
  logic signed [WSum-1:0]    re_d, im_d;
  logic signed [wDataOut-1:0] re_rs, im_rs;

  // Operands widened up front so each product is formed at its full width.
  assign hr_x = WProd'(hr1_q);
  assign hi_x = WProd'(hi1_q);
  assign cr_x = WProd'(cr1_q);
  assign ci_x = WProd'(ci1_q);

  assign rr_x = WSum'(p_rr_q);
  assign ii_x = WSum'(p_ii_q);
  assign ri_x = WSum'(p_ri_q);
  assign ir_x = WSum'(p_ir_q);

`ifdef CE_REMOD_CONJ_EN
  assign re_d = rr_x + ii_x;
  assign im_d = ir_x - ri_x;
`else
  assign re_d = rr_x - ii_x;
  assign im_d = ri_x + ir_x;
`endif

  ce_round_sat #(
    .WIn   (WSum),
    .WOut  (wDataOut),
    .Shift (CE_SCALE_SHIFT)
  ) u_round_re (
    .din  (re3_q),
    .dout (re_rs)
  );

  ce_round_sat #(
    .WIn   (WSum),
    .WOut  (wDataOut),
    .Shift (CE_SCALE_SHIFT)
  ) u_round_im (
    .din  (im3_q),
    .dout (im_rs)
  );

  always_ff @(posedge clk) begin
    if (!rst_n_sync) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      side1_q      <= '0;
      side2_q      <= '0;
      side3_q      <= '0;
      hr1_q        <= '0;
      hi1_q        <= '0;
      cr1_q        <= '0;
      ci1_q        <= '0;
      p_rr_q       <= '0;
      p_ii_q       <= '0;
      p_ri_q       <= '0;
      p_ir_q       <= '0;
      re3_q        <= '0;
      im3_q        <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= '0;
      source_real  <= '0;
      source_imag  <= '0;
      fftpts_out   <= '0;
    end else if (pipe_en) begin
      // S1
      v1_q    <= fwd;
      side1_q <= side_in;
      hr1_q   <= sink_real;
      hi1_q   <= sink_imag;
      cr1_q   <= coef_real;
      ci1_q   <= coef_imag;
      // S2
      v2_q    <= v1_q;
      side2_q <= side1_q;
      p_rr_q  <= hr_x * cr_x;
      p_ii_q  <= hi_x * ci_x;
      p_ri_q  <= hr_x * ci_x;
      p_ir_q  <= hi_x * cr_x;
      // S3
      v3_q    <= v2_q;
      side3_q <= side2_q;
      re3_q   <= re_d;
      im3_q   <= im_d;
      // S4
      source_valid <= v3_q;
      source_sop   <= v3_q && side3_q.sop;
      source_eop   <= v3_q && side3_q.eop;
      source_error <= v3_q ? side3_q.err : 2'b00;
      source_real  <= re_rs;
      source_imag  <= im_rs;
      if (v3_q && side3_q.sop) begin
        fftpts_out <= side3_q.fftpts;
      end
    end
  end

endmodule

// File: tb/tb_ce_rs_remod.sv
// tb_ce_rs_remod: scoreboard bench for ce_rs_remod. The driver runs a packet-level
// reference model on every accepted beat and queues the expected output; an independent
// monitor pops and compares on every output transfer.
module tb_ce_rs_remod;

  localparam int WI = 16;
  localparam int WC = 18;
  localparam int WO = 16;

  logic                 clk;
  logic                 rst_n_sync;
  logic                 sink_valid;
  logic                 sink_ready;
  logic                 sink_sop;
  logic                 sink_eop;
  logic signed [WI-1:0] sink_real;
  logic signed [WI-1:0] sink_imag;
  logic signed [WC-1:0] coef_real;
  logic signed [WC-1:0] coef_imag;
  logic [11:0]          fftpts_in;
  logic                 source_valid;
  logic                 source_ready;
  logic                 source_sop;
  logic                 source_eop;
  logic [1:0]           source_error;
  logic signed [WO-1:0] source_real;
  logic signed [WO-1:0] source_imag;
  logic [11:0]          fftpts_out;

  ce_rs_remod #(
    .wDataIn  (WI),
    .wCoeff   (WC),
    .wDataOut (WO)
  ) dut (
    .clk          (clk),
    .rst_n_sync   (rst_n_sync),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .coef_real    (coef_real),
    .coef_imag    (coef_imag),
    .fftpts_in    (fftpts_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_error (source_error),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .fftpts_out   (fftpts_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [WO-1:0] re;
    logic signed [WO-1:0] im;
    logic                 sop;
    logic                 eop;
    logic [1:0]           err;
    logic [11:0]          fft;
    int                   acc;
    bit                   chk_lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   beat_no = 0;

  // Reference model state: packet-level view of the framing rules.
  bit m_in_pkt = 1'b0;
  bit m_orphan = 1'b0;
  int m_cnt    = 0;
  int m_len    = 0;

  int rdy_mode = 0;
  int rdy_ph   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint scale_sat(input longint x);
    longint y;
    y = (x + 64'sd32768) >>> 16;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic model_accept(input bit sop, input bit eop, input int hr, input int hi,
                              input int cr, input int ci, input int fft, input int acc,
                              input bit chk);
    exp_t   e;
    longint re;
    longint im;
    bit     hit;
    if (!sop && !m_in_pkt) begin
      m_orphan = 1'b1;
      return;
    end
    e.err = 2'b00;
    if (sop) begin
      e.err[0] = m_in_pkt;
      e.err[1] = m_orphan;
      m_orphan = 1'b0;
      m_cnt    = 1;
      m_len    = fft;
      m_in_pkt = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    hit   = (m_cnt == m_len);
    e.sop = sop;
    e.eop = eop || hit;
    if (eop != hit) e.err[0] = 1'b1;
    if (e.eop) m_in_pkt = 1'b0;
`ifdef CE_REMOD_CONJ_EN
    re = longint'(hr) * cr + longint'(hi) * ci;
    im = longint'(hi) * cr - longint'(hr) * ci;
`else
    re = longint'(hr) * cr - longint'(hi) * ci;
    im = longint'(hr) * ci + longint'(hi) * cr;
`endif
    e.re      = 16'(scale_sat(re));
    e.im      = 16'(scale_sat(im));
    e.fft     = 12'(m_len);
    e.acc     = acc;
    e.chk_lat = chk;
    sb.push_back(e);
  endtask

  // Called right after a posedge (+1); returns right after the accepting posedge (+1).
  task automatic send(input bit sop, input bit eop, input int hr, input int hi, input int cr,
                      input int ci, input int fft, input bit chk_lat);
    int waited;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_real  = 16'(hr);
    sink_imag  = 16'(hi);
    coef_real  = 18'(cr);
    coef_imag  = 18'(ci);
    fftpts_in  = 12'(fft);
    sink_valid = 1'b1;
    waited     = 0;
    @(negedge clk);
    while (!sink_ready && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    if (!sink_ready) begin
      errors++;
      $display("FAIL sink_accept_timeout: sink_ready=%0b after %0d cycles, required 1",
               sink_ready, waited);
    end else begin
      // Accepting edge is the next one; cyc holds cyc+1 after it.
      model_accept(sop, eop, hr, hi, cr, ci, fft, cyc + 1, chk_lat);
    end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected beats never appeared, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator.
  initial begin
    source_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: source_ready = 1'b1;
        1: begin
          source_ready = (rdy_ph == 0) || (rdy_ph == 3);
          rdy_ph       = (rdy_ph + 1) % 4;
        end
        default: source_ready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  // Monitor: inputs change only just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n_sync) begin
      checks++;
      if (sink_ready !== (!source_valid || source_ready)) begin
        errors++;
        $display("FAIL sink_ready_mirror: got %b, required %b", sink_ready,
                 (!source_valid || source_ready));
      end
      if (source_valid && source_ready) begin
        checks++;
        beat_no++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat %0d: got re=%0d im=%0d, required no output", beat_no,
                   source_real, source_imag);
        end else begin
          e = sb.pop_front();
          if (source_real !== e.re || source_imag !== e.im || source_sop !== e.sop ||
              source_eop !== e.eop || source_error !== e.err ||
              (e.sop && fftpts_out !== e.fft)) begin
            errors++;
            $display({"FAIL beat %0d: got re=%0d im=%0d sop=%b eop=%b err=%b fft=%0d, ",
                      "required re=%0d im=%0d sop=%b eop=%b err=%b fft=%0d"},
                     beat_no, source_real, source_imag, source_sop, source_eop, source_error,
                     fftpts_out, e.re, e.im, e.sop, e.eop, e.err, e.fft);
          end
          if (e.chk_lat) begin
            checks++;
            // Output register loads on the 4th enabled edge counting the accepting one.
            if (cyc - e.acc != 3) begin
              errors++;
              $display("FAIL latency: got %0d edges after accept, required 3", cyc - e.acc);
            end
          end
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if (source_valid !== 1'b0 || source_sop !== 1'b0 || source_eop !== 1'b0 ||
        source_error !== 2'b00 || fftpts_out !== 12'd0) begin
      errors++;
      $display("FAIL %s: got valid=%b sop=%b eop=%b err=%b fft=%0d, required all 0", name,
               source_valid, source_sop, source_eop, source_error, fftpts_out);
    end
  endtask

  initial begin
    int len;
    int mode;
    int n_beats;
    rst_n_sync = 1'b0;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    sink_real  = '0;
    sink_imag  = '0;
    coef_real  = '0;
    coef_imag  = '0;
    fftpts_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk);
    #1;
    rst_n_sync = 1'b1;

    // Identity coefficient, 4-beat packet, latency check on first beat.
    for (int i = 0; i < 4; i++) send(i == 0, i == 3, 100, 50, 65536, 0, 4, i == 0);
    drain();
    // C = j, single-beat packet.
    send(1'b1, 1'b1, 100, 50, 0, 65536, 1, 1'b0);
    // Rounding edges and imaginary saturation.
    send(1'b1, 1'b0, 1, 0, 32768, 0, 3, 1'b0);
    send(1'b0, 1'b0, -1, 0, 32768, 0, 3, 1'b0);
    send(1'b0, 1'b1, 32767, 32767, 65536, 65536, 3, 1'b0);
    drain();
    // Early eop on beat 10 of 12, then 3 orphans, then a valid packet.
    for (int i = 0; i < 10; i++) send(i == 0, i == 9, i * 7, -i, 65536, 0, 12, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 5, 5, 65536, 0, 0, 1'b0);
    send(1'b1, 1'b0, 11, 22, 65536, 0, 2, 1'b0);
    send(1'b0, 1'b1, 33, 44, 65536, 0, 2, 1'b0);
    drain();
    // Length reached without eop, trailing orphans, restart inside a packet.
    for (int i = 0; i < 5; i++) send(i == 0, 1'b0, 300 + i, 7, 65536, 0, 3, 1'b0);
    send(1'b1, 1'b0, 1, 2, 65536, 0, 4, 1'b0);
    send(1'b0, 1'b0, 3, 4, 65536, 0, 4, 1'b0);
    send(1'b1, 1'b0, 5, 6, 65536, 0, 2, 1'b0);
    send(1'b0, 1'b1, 7, 8, 65536, 0, 2, 1'b0);
    drain();
    // Backpressure pattern 1,0,0,1.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(i == 0, i == 7, 1000 * i - 3000, 17 * i, 60000, -9000, 8,
                                     1'b0);
    drain();
    rdy_mode = 0;
    // Reset mid-packet.
    for (int i = 0; i < 3; i++) send(i == 0, 1'b0, 9, 9, 65536, 0, 8, 1'b0);
    rst_n_sync = 1'b0;
    sb.delete();
    m_in_pkt = 1'b0;
    m_orphan = 1'b0;
    @(posedge clk);
    #1;
    rst_n_sync = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_midpacket_reset");
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(i == 0, i == 3, 40 * i, -40 * i, 65536, 65536, 4, 1'b0);
    drain();
    // Randomised traffic with random backpressure and framing faults.
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      len  = $urandom_range(16, 1);
      mode = $urandom_range(9, 0);
      n_beats = len;
      if (mode == 0) n_beats = $urandom_range(len, 1);  // early eop
      if (mode == 1) n_beats = len + 2;                 // missing eop, trailing orphans
      if (mode == 2) begin
        for (int k = 0; k < 2; k++) send(1'b0, 1'b0, 1, 1, 65536, 0, 0, 1'b0);
      end
      for (int i = 0; i < n_beats; i++) begin
        send(i == 0, (mode != 1) && (i == n_beats - 1),
             int'($urandom_range(65535, 0)) - 32768, int'($urandom_range(65535, 0)) - 32768,
             int'($urandom_range(262143, 0)) - 131072, int'($urandom_range(262143, 0)) - 131072,
             len, 1'b0);
        if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
      end
    end
    rdy_mode = 0;
    drain();
    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ce_rs_remod.md
Name: ce_rs_remod

Overview:
- Re-modulation block, the inverse of the LS divider: multiplies a channel-estimate stream H[k] by the transmitted reference symbol C[k] to rebuild the expected received RS, Y[k] = H[k]·C[k]/65536.
- Sits after the DCT-domain channel estimator and feeds the noise/interference estimator, which subtracts Y from the received RS.
- Streaming, packet-framed (sop/eop), one complex sample per clock, backpressure-aware.
- C[k] arrives from the RS-tx generator, aligned on side-band coefficient ports.

Parameters:
- wDataIn, 16, width of signed H real/imag.
- wCoeff, 18, width of signed C real/imag; |C| nominally 65536.
- wDataOut, 16, width of signed output real/imag.

Ports:
- clk  in  1  clock
- rst_n_sync  in  1  synchronous reset, active low
- sink_valid  in  1  H beat valid
- sink_ready  out  1  block accepts beat
- sink_sop  in  1  first subcarrier of packet
- sink_eop  in  1  last subcarrier of packet
- sink_real  in  wDataIn  H real, signed
- sink_imag  in  wDataIn  H imag, signed
- coef_real  in  wCoeff  C real, signed, valid with sink beat
- coef_imag  in  wCoeff  C imag, signed, valid with sink beat
- fftpts_in  in  12  expected packet length, sampled on accepted sop beat
- source_valid  out  1  output beat valid
- source_ready  in  1  downstream accepts
- source_sop  out  1  output sop
- source_eop  out  1  output eop
- source_error  out  2  [0] length error, [1] orphan beats dropped before this packet
- source_real  out  wDataOut  Y real, signed
- source_imag  out  wDataOut  Y imag, signed
- fftpts_out  out  12  length latched at sop

Behaviour:
- Reset (rst_n_sync=0 at clk edge): all pipeline registers, valid bits, sop/eop, error, counter, fftpts_out cleared to 0; FSM to IDLE. Reset mid-packet discards in-flight data silently.
- Pipeline enable: pipe_en = !source_valid || source_ready. sink_ready = pipe_en (combinational). A beat is accepted when sink_valid && sink_ready. No stage advances when pipe_en=0.
- Latency: 4 enabled cycles. S1 registers H, C, and flags. S2 forms four products, each wDataIn+wCoeff bits. S3 forms re = Hr·Cr − Hi·Ci and im = Hr·Ci + Hi·Cr (wDataIn+wCoeff+1 bits). S4 rounds and saturates into the output registers.
- Scaling: add 2^15, arithmetic shift right by 16 (round half up). Saturate to [−2^(wDataOut−1), 2^(wDataOut−1)−1].
- FSM IDLE:
  - Accepted beat with sop → RUN; cnt=1; latch fftpts_in.
  - Accepted beat without sop → discarded (not forwarded); orphan flag set.
- FSM RUN, each accepted beat increments cnt.
  - eop with cnt+1==len → normal end, back to IDLE.
  - eop with cnt+1!=len → error[0]=1 on that eop output beat; back to IDLE.
  - cnt+1==len without eop → output eop forced to 1 with error[0]=1; back to IDLE. Further beats are orphans until the next sop.
  - sop in RUN → treated as a new packet start: cnt=1, len relatched, error[0]=1 on that output sop beat.
  - sop and eop on the same beat with len==1 → valid single-beat packet.
- Orphan flag: reported as error[1] on the next output sop beat, then cleared. An orphan arriving in the same cycle as that sop beat re-sets the flag for the following packet.
- fftpts_out updates when the sop beat reaches the output stage.
- source_error is 0 on all other beats.

Optional Feature:
- CE_REMOD_CONJ_EN
  - Defined: multiply by conj(C), i.e. re = Hr·Cr + Hi·Ci, im = Hi·Cr − Hr·Ci. This lets the same block serve as an LS divider for unit-modulus sequences.
  - Undefined: plain product H·C as above.
  - Latency, scaling and framing are identical in both builds.

Decomposition:
- Shared package ce_pkg:
  - CE_WCOEFF=18
  - CE_SCALE_SHIFT=16
  - CE_ERR_LEN=0
  - CE_ERR_ORPHAN=1
  - FSM state typedef {IDLE, RUN}
- One sub-module, ce_round_sat: parameterised round-half-up, shift, and saturate, used twice (real, imag); purely combinational inside S4.

Test Plan:
- fftpts_in=4, H=(100,50) on all beats, C=(65536,0), source_ready=1 → output (100,50) ×4, sop on beat 1, eop on beat 4, error 0, first output 4 cycles after first accept.
- H=(100,50), C=(0,65536) → (−50,100). With CE_REMOD_CONJ_EN defined → (50,−100).
- H=(1,0), C=(32768,0) → (1,0) (round up). H=(−1,0), C=(32768,0) → (0,0). H=(32767,32767), C=(65536,65536) → (0,32767), imag saturated.
- fftpts_in=12, sink_eop asserted on the 10th beat → 10 outputs, error=2'b01 on the 10th beat. Then 3 beats without sop, then a valid packet → the 3 beats are dropped and the next output sop carries error=2'b10.
- 8-beat packet with source_ready toggling 1,0,0,1 repeating → sink_ready mirrors the stall, no beat lost or duplicated, output order and sop/eop preserved.
- Assert rst_n_sync=0 for 1 cycle mid-packet → source_valid=0 the next cycle, and a fresh packet afterwards is processed with error=0.
